// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: per-register commands, PC enable,
// halt drain and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             de_memread,
  input  logic [REG_W-1:0] de_rt,
  input  logic [REG_W-1:0] rs_dec,
  input  logic [REG_W-1:0] rt_dec,
  input  logic             jump_dec,
  input  logic             branch_ex,
  input  logic             halt_mem,
  output logic [1:0]       fd_state,
  output logic [1:0]       de_state,
  output logic [1:0]       em_state,
  output logic [1:0]       mw_state,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] PIPE_STALL  = 2'b00;
  localparam logic [1:0] PIPE_ENABLE = 2'b01;
  localparam logic [1:0] PIPE_NOP    = 2'b10;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             mem_wait, load_use;

  assign mem_wait = dmem_req & ~dhit;
  // A load to $0 never creates a real dependency.
  assign load_use = de_memread & (de_rt != '0) & ((de_rt == rs_dec) | (de_rt == rt_dec));

  // Next-state, register commands and counter increment requests.
  always_comb begin
    state_d   = state_q;
    fd_state  = PIPE_ENABLE;
    de_state  = PIPE_ENABLE;
    em_state  = PIPE_ENABLE;
    mw_state  = PIPE_ENABLE;
    pc_en     = 1'b1;
    halted    = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          fd_state = PIPE_STALL;
          de_state = PIPE_STALL;
          em_state = PIPE_STALL;
          mw_state = PIPE_STALL;
          pc_en    = 1'b0;
        end else if (halt_mem) begin
          // Halt overrides all younger-instruction hazards: only MEM/WB keeps flowing.
          state_d  = StDrain;
          fd_state = PIPE_NOP;
          de_state = PIPE_NOP;
          em_state = PIPE_NOP;
          pc_en    = 1'b0;
        end else if (branch_ex) begin
          fd_state  = PIPE_NOP;
          de_state  = PIPE_NOP;
          flush_inc = 1'b1;
        end else if (load_use) begin
          fd_state = PIPE_STALL;
          de_state = PIPE_NOP;
          pc_en    = 1'b0;
        end else if (jump_dec) begin
          fd_state  = PIPE_NOP;
          flush_inc = 1'b1;
        end else if (!ihit) begin
          fd_state = PIPE_NOP;
          pc_en    = 1'b0;
        end
      end
      StDrain: begin
        state_d  = StHalted;
        fd_state = PIPE_NOP;
        de_state = PIPE_NOP;
        em_state = PIPE_NOP;
        pc_en    = 1'b0;
      end
      StHalted: begin
        fd_state = PIPE_STALL;
        de_state = PIPE_STALL;
        em_state = PIPE_STALL;
        mw_state = PIPE_STALL;
        pc_en    = 1'b0;
        halted   = 1'b1;
      end
      default: state_d = StRun;
    endcase
    stall_inc = (state_q == StRun) & ~pc_en;
  end

  // Saturating counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // FSM and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=4 to reach saturation quickly).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;

  // {fd, de, em, mw} command patterns
  localparam logic [7:0] AllEn   = 8'b01_01_01_01;
  localparam logic [7:0] AllSt   = 8'b00_00_00_00;
  localparam logic [7:0] LoadUse = 8'b00_10_01_01;
  localparam logic [7:0] Branch  = 8'b10_10_01_01;
  localparam logic [7:0] FdNop   = 8'b10_01_01_01;
  localparam logic [7:0] Drain   = 8'b10_10_10_01;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, dmem_req, de_memread, jump_dec, branch_ex, halt_mem;
  logic [REG_W-1:0] de_rt, rs_dec, rt_dec;
  logic [1:0]       fd_state, de_state, em_state, mw_state;
  logic             pc_en, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W),
    .REG_W(REG_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ihit      (ihit),
    .dhit      (dhit),
    .dmem_req  (dmem_req),
    .de_memread(de_memread),
    .de_rt     (de_rt),
    .rs_dec    (rs_dec),
    .rt_dec    (rt_dec),
    .jump_dec  (jump_dec),
    .branch_ex (branch_ex),
    .halt_mem  (halt_mem),
    .fd_state  (fd_state),
    .de_state  (de_state),
    .em_state  (em_state),
    .mw_state  (mw_state),
    .pc_en     (pc_en),
    .halted    (halted),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; de_memread = 1'b0;
    jump_dec = 1'b0; branch_ex = 1'b0; halt_mem = 1'b0;
    de_rt = '0; rs_dec = '0; rt_dec = '0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] st, input logic pc,
                         input logic hl);
    #1;
    check_eq({tag, ".st"}, 32'({fd_state, de_state, em_state, mw_state}), 32'(st));
    check_eq({tag, ".pc"}, 32'(pc_en), 32'(pc));
    check_eq({tag, ".halted"}, 32'(halted), 32'(hl));
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    check_eq({tag, ".stall"}, 32'(stall_cnt), 32'(s));
    check_eq({tag, ".flush"}, 32'(flush_cnt), 32'(f));
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    chk_out("rst_out", AllEn, 1'b1, 1'b0);
    chk_cnt("rst_cnt", 0, 0);
    nRST = 1'b1;
    tick();

    // Plain run
    chk_out("run", AllEn, 1'b1, 1'b0);
    tick();
    chk_cnt("run_cnt", 0, 0);

    // Load-use on rs
    de_memread = 1'b1; de_rt = 5'd5; rs_dec = 5'd5;
    chk_out("lu_rs", LoadUse, 1'b0, 1'b0);
    tick();
    chk_cnt("lu_rs_cnt", 1, 0);

    // Load to $0: no hazard
    de_rt = 5'd0; rs_dec = 5'd0;
    chk_out("lu_r0", AllEn, 1'b1, 1'b0);
    tick();
    chk_cnt("lu_r0_cnt", 1, 0);

    // Load-use on rt
    de_rt = 5'd7; rs_dec = 5'd3; rt_dec = 5'd7;
    chk_out("lu_rt", LoadUse, 1'b0, 1'b0);
    tick();
    chk_cnt("lu_rt_cnt", 2, 0);
    idle();

    // Dcache wait masks a branch for 3 cycles
    dmem_req = 1'b1; dhit = 1'b0; branch_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("dwait", AllSt, 1'b0, 1'b0);
      tick();
    end
    chk_cnt("dwait_cnt", 5, 0);
    dhit = 1'b1;
    chk_out("br", Branch, 1'b1, 1'b0);
    tick();
    chk_cnt("br_cnt", 5, 1);
    idle();

    // Branch beats load-use
    branch_ex = 1'b1; de_memread = 1'b1; de_rt = 5'd9; rs_dec = 5'd9;
    chk_out("br_lu", Branch, 1'b1, 1'b0);
    tick();
    chk_cnt("br_lu_cnt", 5, 2);
    idle();

    // Jump with icache miss still advances PC
    jump_dec = 1'b1; ihit = 1'b0;
    chk_out("jmp", FdNop, 1'b1, 1'b0);
    tick();
    chk_cnt("jmp_cnt", 5, 3);
    idle();

    // Icache miss
    ihit = 1'b0;
    chk_out("imiss", FdNop, 1'b0, 1'b0);
    tick();
    chk_cnt("imiss_cnt", 6, 3);
    idle();

    // Halt blocked by dcache wait
    halt_mem = 1'b1; dmem_req = 1'b1; dhit = 1'b0;
    chk_out("halt_wait", AllSt, 1'b0, 1'b0);
    tick();
    chk_cnt("halt_wait_cnt", 7, 3);

    // Halt enters drain
    dmem_req = 1'b0;
    chk_out("halt_go", Drain, 1'b0, 1'b0);
    tick();
    chk_cnt("halt_go_cnt", 8, 3);

    // Drain ignores inputs
    idle();
    dmem_req = 1'b1; branch_ex = 1'b1;
    chk_out("drain", Drain, 1'b0, 1'b0);
    tick();
    chk_cnt("drain_cnt", 8, 3);

    // Halted persists, counters frozen
    for (int i = 0; i < 3; i++) begin
      branch_ex = i[0]; jump_dec = 1'b1; ihit = 1'b0;
      chk_out("halted", AllSt, 1'b0, 1'b1);
      tick();
    end
    chk_cnt("halted_cnt", 8, 3);

    // Async reset returns to RUN immediately
    idle();
    #2;
    nRST = 1'b0;
    chk_out("rst2_out", AllEn, 1'b1, 1'b0);
    chk_cnt("rst2_cnt", 0, 0);
    #3;
    nRST = 1'b1;
    tick();
    chk_out("rst2_run", AllEn, 1'b1, 1'b0);

    // Stall counter saturation
    ihit = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk_cnt("sat14", 14, 0);
    tick();
    chk_cnt("sat15", 15, 0);
    for (int i = 0; i < 5; i++) tick();
    chk_cnt("sat20", 15, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
